cfu_cmd_queue: RTL and testbench

- Command-queueing stage between the CPU custom-instruction port and the conv1d compute core.
- Posted commands (weight/input loads, config writes) are acknowledged to the CPU immediately and buffered in a FIFO, so the CPU does not stall while the core is busy.
- Blocking (read) commands wait until the FIFO drains, then execute on the core. The core's result is returned on the CPU response channel.

---
 rtl/cfu_queue_pkg.sv | 22 ++
 rtl/cfu_cmd_queue_if.sv | 36 +++
 rtl/cfu_cmd_fifo.sv | 64 ++++++
 rtl/cfu_cmd_queue.sv | 157 +++++++++++++++
 tb/tb_cfu_cmd_queue.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfu_queue_pkg.sv
// Shared types for the CFU command queue: FSM states and the queued command entry.
package cfu_queue_pkg;

    localparam int unsigned FUNCT7_W = 7;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRspPost,
        StDrain,
        StIssue,
        StWait,
        StRspRead
    } state_e;

    typedef struct packed {
        logic [FUNCT7_W-1:0] funct7;
        logic [DATA_W-1:0]   inp0;
        logic [DATA_W-1:0]   inp1;
    } cmd_entry_t;

endpackage

// File: rtl/cfu_cmd_queue_if.sv
// CPU command/response channel plus core issue/return channel of the CFU command queue.
// The slave modport is the queue's view; master is the surrounding CPU/core environment.
interface cfu_cmd_queue_if;
    import cfu_queue_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [9:0]          cmd_payload_function_id;
    logic [DATA_W-1:0]   cmd_payload_inputs_0;
    logic [DATA_W-1:0]   cmd_payload_inputs_1;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_payload_outputs_0;
    logic                core_cmd_valid;
    logic                core_cmd_ready;
    logic [FUNCT7_W-1:0] core_funct7;
    logic [DATA_W-1:0]   core_inp0;
    logic [DATA_W-1:0]   core_inp1;
    logic [DATA_W-1:0]   core_ret;
    logic                core_ret_valid;

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready, core_cmd_ready, core_ret, core_ret_valid,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0,
        output core_cmd_valid, core_funct7, core_inp0, core_inp1
    );

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready, core_cmd_ready, core_ret, core_ret_valid,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0,
        input  core_cmd_valid, core_funct7, core_inp0, core_inp1
    );

endinterface

// File: rtl/cfu_cmd_fifo.sv
// Synchronous FIFO of command entries with binary pointers and an occupancy count.
module cfu_cmd_fifo
    import cfu_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push_i,
    input  cmd_entry_t      wdata_i,
    input  logic            pop_i,
    output cmd_entry_t      rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    cmd_entry_t      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop never frees room for a same-cycle push: push is gated on the registered full.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cfu_cmd_queue.sv
// CFU command queue: posted commands are acked at once and buffered; reads drain, issue, return.
// Optional CFU_QUEUE_STATS_EN adds posted/stall counters readable through STAT_FUNCT7.
module cfu_cmd_queue
    import cfu_queue_pkg::*;
#(
    parameter int unsigned        DEPTH       = 4,
`ifdef CFU_QUEUE_STATS_EN
    parameter logic [FUNCT7_W-1:0] STAT_FUNCT7 = 7'd127,
`endif
    parameter logic [FUNCT7_W-1:0] READ_FUNCT7 = 7'd1
) (
    input logic            clk,
    input logic            reset_n,
    cfu_cmd_queue_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    state_e              state_q, state_d;
    cmd_entry_t          hold_q, hold_d;
    logic [DATA_W-1:0]   ret_q, ret_d;
    cmd_entry_t          cmd_in, fifo_head, core_entry;
    logic                fifo_full, fifo_empty, push, pop;
    logic [CntW-1:0]     unused_fifo_count;
    logic [FUNCT7_W-1:0] funct7;
    logic                accept, is_read, is_stat;
    logic                unused_fid;

    assign funct7     = bus.cmd_payload_function_id[9:3];
    assign unused_fid = ^bus.cmd_payload_function_id[2:0];
    assign cmd_in     = '{funct7: funct7,
                          inp0:   bus.cmd_payload_inputs_0,
                          inp1:   bus.cmd_payload_inputs_1};

    assign bus.cmd_ready = (state_q == StIdle) && !fifo_full;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign is_read       = (funct7 == READ_FUNCT7);
    assign push          = accept && !is_read && !is_stat;
    assign pop           = !fifo_empty && bus.core_cmd_ready;

    cfu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (cmd_in),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    // Queued entries always go first; the held read is only presented once the FIFO is empty.
    always_comb begin
        core_entry         = '0;
        bus.core_cmd_valid = 1'b0;
        if (!fifo_empty) begin
            core_entry         = fifo_head;
            bus.core_cmd_valid = 1'b1;
        end else if (state_q == StIssue) begin
            core_entry         = hold_q;
            bus.core_cmd_valid = 1'b1;
        end
    end

    assign bus.core_funct7 = core_entry.funct7;
    assign bus.core_inp0   = core_entry.inp0;
    assign bus.core_inp1   = core_entry.inp1;

    assign bus.rsp_valid             = (state_q == StRspPost) || (state_q == StRspRead);
    assign bus.rsp_payload_outputs_0 = (state_q == StRspRead) ? ret_q : '0;

`ifdef CFU_QUEUE_STATS_EN
    logic [DATA_W-1:0] posted_cnt_q, posted_cnt_d;
    logic [DATA_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [DATA_W-1:0] stat_val;

    assign is_stat  = (funct7 == STAT_FUNCT7);
    assign stat_val = bus.cmd_payload_inputs_0[0] ? stall_cnt_q : posted_cnt_q;

    always_comb begin
        posted_cnt_d = posted_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (push && (posted_cnt_q != '1)) posted_cnt_d = posted_cnt_q + DATA_W'(1);
        if (bus.cmd_valid && !bus.cmd_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + DATA_W'(1);
        end
        // The read value is captured from the old counts, so clearing here is "after the read".
        if (accept && is_stat && bus.cmd_payload_inputs_1[0]) begin
            posted_cnt_d = '0;
            stall_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            posted_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            posted_cnt_q <= posted_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end
`else
    logic [DATA_W-1:0] stat_val;

    assign is_stat  = 1'b0;
    assign stat_val = '0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ret_d   = ret_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_stat) begin
                        ret_d   = stat_val;
                        state_d = StRspRead;
                    end else if (is_read) begin
                        hold_d  = cmd_in;
                        state_d = StDrain;
                    end else begin
                        state_d = StRspPost;
                    end
                end
            end
            StRspPost: if (bus.rsp_ready) state_d = StIdle;
            StDrain:   if (fifo_empty) state_d = StIssue;
            StIssue:   if (bus.core_cmd_ready) state_d = StWait;
            StWait: begin
                if (bus.core_ret_valid) begin
                    ret_d   = bus.core_ret;
                    state_d = StRspRead;
                end
            end
            StRspRead: if (bus.rsp_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ret_q   <= ret_d;
        end
    end

endmodule

// File: tb/tb_cfu_cmd_queue.sv
// Directed bench for cfu_cmd_queue: posted acks, backpressure, drain-then-read, reset, stats.
module tb_cfu_cmd_queue;
    import cfu_queue_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    int         checks = 0;
    int         failures = 0;
    cmd_entry_t log_q[$];

    cfu_cmd_queue_if bus ();

    cfu_cmd_queue dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Record every command the core accepts.
    always @(posedge clk) begin
        if (bus.core_cmd_valid && bus.core_cmd_ready) begin
            log_q.push_back('{funct7: bus.core_funct7, inp0: bus.core_inp0, inp1: bus.core_inp1});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = {f7, 3'b000};
        bus.cmd_payload_inputs_0    = a;
        bus.cmd_payload_inputs_1    = b;
    endtask

    // Posted command: accepted now, zero-payload response the next cycle, taken at once.
    task automatic post(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        drive(f7, a, b);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_rsp_payload"}, bus.rsp_payload_outputs_0, 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic stat_read(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input string tag);
        drive(7'd127, a, b);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_payload"}, bus.rsp_payload_outputs_0, exp);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.cmd_valid               = 1'b0;
        bus.cmd_payload_function_id = '0;
        bus.cmd_payload_inputs_0    = '0;
        bus.cmd_payload_inputs_1    = '0;
        bus.rsp_ready               = 1'b0;
        bus.core_cmd_ready          = 1'b0;
        bus.core_ret                = '0;
        bus.core_ret_valid          = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_payload", bus.rsp_payload_outputs_0, 32'd0);
        chk("rst_core_valid", 32'(bus.core_cmd_valid), 32'd0);
        chk("rst_core_f7", 32'(bus.core_funct7), 32'd0);
        chk("rst_core_inp0", bus.core_inp0, 32'd0);
        reset_n = 1'b1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Single posted command with a ready core
        bus.core_cmd_ready = 1'b1;
        drive(7'd5, 32'hA, 32'hB);
        chk("p1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("p1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("p1_rsp_payload", bus.rsp_payload_outputs_0, 32'd0);
        chk("p1_cmd_ready_blocked", 32'(bus.cmd_ready), 32'd0);
        chk("p1_core_valid", 32'(bus.core_cmd_valid), 32'd1);
        chk("p1_core_f7", 32'(bus.core_funct7), 32'd5);
        chk("p1_core_inp0", bus.core_inp0, 32'hA);
        chk("p1_core_inp1", bus.core_inp1, 32'hB);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("p1_rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("p1_core_idle", 32'(bus.core_cmd_valid), 32'd0);
        chk("p1_log_size", 32'(log_q.size()), 32'd1);
        log_q.delete();

        // Fill the FIFO with the core stalled; fifth command waits for a pop
        bus.core_cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) post(7'(8 + i), 32'h100 + i, 32'h200 + i, "fill");
        drive(7'd12, 32'h104, 32'h204);
        chk("full_ready0", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("full_ready1", 32'(bus.cmd_ready), 32'd0);
        bus.core_cmd_ready = 1'b1;
        chk("full_ready_pop_same_cycle", 32'(bus.cmd_ready), 32'd0);
        chk("full_head_f7", 32'(bus.core_funct7), 32'd8);
        tick();
        bus.core_cmd_ready = 1'b0;
        chk("full_ready_after_pop", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("fifth_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready      = 1'b0;
        bus.core_cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.core_cmd_ready = 1'b0;
        chk("fill_drained", 32'(bus.core_cmd_valid), 32'd0);
        chk("fill_log_size", 32'(log_q.size()), 32'd5);
        if (log_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("fill_order_f7", 32'(log_q[i].funct7), 32'(8 + i));
                chk("fill_order_inp0", log_q[i].inp0, 32'h100 + i);
                chk("fill_order_inp1", log_q[i].inp1, 32'h200 + i);
            end
        end
        log_q.delete();

        // Three posted commands, then a read that must wait for the drain
        for (int i = 0; i < 3; i++) post(7'(20 + i), 32'h300 + i, 32'h400 + i, "pre");
        drive(7'd1, 32'h77, 32'h88);
        chk("rd_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("rd_no_rsp_in_drain", 32'(bus.rsp_valid), 32'd0);
        chk("rd_head_f7", 32'(bus.core_funct7), 32'd20);
        bus.core_cmd_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("rd_bubble_after_drain", 32'(bus.core_cmd_valid), 32'd0);
        chk("rd_log_three_pops", 32'(log_q.size()), 32'd3);
        tick();
        chk("rd_issue_valid", 32'(bus.core_cmd_valid), 32'd1);
        chk("rd_issue_f7", 32'(bus.core_funct7), 32'd1);
        chk("rd_issue_inp0", bus.core_inp0, 32'h77);
        chk("rd_issue_inp1", bus.core_inp1, 32'h88);
        tick();
        bus.core_cmd_ready = 1'b0;
        chk("rd_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rd_log_read_last", 32'(log_q.size()), 32'd4);
        tick();
        tick();
        bus.core_ret       = 32'h1234;
        bus.core_ret_valid = 1'b1;
        tick();
        bus.core_ret_valid = 1'b0;
        bus.core_ret       = 32'h0;
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_rsp_payload", bus.rsp_payload_outputs_0, 32'h1234);

        // Response backpressure: payload stable, new commands blocked
        drive(7'd3, 32'h1, 32'h2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rsp_payload", bus.rsp_payload_outputs_0, 32'h1234);
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("hold_released", 32'(bus.rsp_valid), 32'd0);
        chk("hold_idle_ready", 32'(bus.cmd_ready), 32'd1);
        log_q.delete();

        // Reset with two entries queued behind a pending read
        post(7'd30, 32'h30, 32'h31, "rq");
        post(7'd31, 32'h32, 32'h33, "rq");
        chk("rq_core_valid", 32'(bus.core_cmd_valid), 32'd1);
        drive(7'd1, 32'h5, 32'h6);
        tick();
        bus.cmd_valid = 1'b0;
        reset_n       = 1'b0;
        #1;
        chk("rq_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rq_rst_rsp_payload", bus.rsp_payload_outputs_0, 32'd0);
        chk("rq_rst_core_valid", 32'(bus.core_cmd_valid), 32'd0);
        chk("rq_rst_core_f7", 32'(bus.core_funct7), 32'd0);
        chk("rq_rst_core_inp0", bus.core_inp0, 32'd0);
        chk("rq_rst_core_inp1", bus.core_inp1, 32'd0);
        tick();
        reset_n = 1'b1;
        chk("rq_after_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rq_after_core_valid", 32'(bus.core_cmd_valid), 32'd0);

        // Reset while waiting on the core; a late core_ret_valid is ignored
        bus.core_cmd_ready = 1'b1;
        drive(7'd1, 32'h5, 32'h6);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        bus.core_cmd_ready = 1'b0;
        chk("wt_in_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("wt_in_wait_blocked", 32'(bus.cmd_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("wt_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("wt_rst_core_valid", 32'(bus.core_cmd_valid), 32'd0);
        tick();
        reset_n            = 1'b1;
        bus.core_ret       = 32'hDEAD;
        bus.core_ret_valid = 1'b1;
        tick();
        bus.core_ret_valid = 1'b0;
        chk("wt_late_ret_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("wt_late_ret_payload", bus.rsp_payload_outputs_0, 32'd0);
        tick();
        chk("wt_late_ret_no_rsp2", 32'(bus.rsp_valid), 32'd0);
        chk("wt_idle_ready", 32'(bus.cmd_ready), 32'd1);

`ifdef CFU_QUEUE_STATS_EN
        // Statistics counters
        bus.core_cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) post(7'(40 + i), 32'h500 + i, 32'h600 + i, "st");
        stat_read(32'd0, 32'd0, 32'd3, "stat_plain");
        stat_read(32'd0, 32'd1, 32'd3, "stat_clear");
        stat_read(32'd0, 32'd0, 32'd0, "stat_after_clear");
        bus.core_cmd_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
